reorder_buffer: RTL and testbench

- In-order retirement buffer for the OoO core.
- Decode allocates one entry per instruction and receives a ROB tag; the rename table stores that tag.
- Writeback marks entries complete with result data; the head entry retires in program order to the ARF.
- Commit broadcasts the retiring tag so the rename table can clear its pending mapping. An exception at the head flushes the whole buffer.

---
 rtl/reorder_buffer.sv | 150 +++++++++++++++
 tb/tb_reorder_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// reorder_buffer: in-order retirement buffer; allocate at tail, complete by tag,
// retire from head, flush everything when the head entry carries an exception.
module reorder_buffer #(
  parameter int ROB_COUNT  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  input  logic                         alloc_has_rd_i,
  input  logic [4:0]                   alloc_rd_i,
  input  logic [ADDR_WIDTH-1:0]        alloc_pc_i,
  output logic [$clog2(ROB_COUNT)-1:0] alloc_tag_o,
  input  logic                         wb_valid_i,
  input  logic [$clog2(ROB_COUNT)-1:0] wb_tag_i,
  input  logic [DATA_WIDTH-1:0]        wb_data_i,
  input  logic                         wb_exc_i,
  input  logic [$clog2(ROB_COUNT)-1:0] rd_tag_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic                         rd_ready_o,
  output logic                         commit_valid_o,
  input  logic                         commit_ready_i,
  output logic                         commit_has_rd_o,
  output logic [4:0]                   commit_rd_o,
  output logic [DATA_WIDTH-1:0]        commit_data_o,
  output logic [$clog2(ROB_COUNT)-1:0] commit_tag_o,
  output logic                         flush_o,
  output logic [ADDR_WIDTH-1:0]        flush_pc_o,
  output logic [$clog2(ROB_COUNT):0]   count_o
);

  localparam int TAG_W = $clog2(ROB_COUNT);
  localparam int PTR_W = TAG_W + 1;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [TAG_W-1:0]      head_idx;
  logic [TAG_W-1:0]      tail_idx;
  logic [ROB_COUNT-1:0]  busy;
  logic [ROB_COUNT-1:0]  done;
  logic [ROB_COUNT-1:0]  exc;
  logic [ROB_COUNT-1:0]  has_rd;
  logic [4:0]            rd_q   [ROB_COUNT];
  logic [ADDR_WIDTH-1:0] pc_q   [ROB_COUNT];
  logic [DATA_WIDTH-1:0] data_q [ROB_COUNT];
  logic [0:0]            state;
  logic [0:0]            state_next;
  logic                  full;
  logic                  head_ok;
  logic                  head_exc;
  logic                  alloc_fire;
  logic                  retire_fire;
  logic                  wb_hit;

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign head_ok     = busy[head_idx] && done[head_idx] && !exc[head_idx];
  assign head_exc    = busy[head_idx] && done[head_idx] && exc[head_idx];
  assign wb_hit      = wb_valid_i && busy[wb_tag_i];

  assign alloc_ready_o = !full && !flush_o;
  assign alloc_tag_o   = tail_idx;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign retire_fire   = commit_valid_o && commit_ready_i;

  assign rd_data_o  = data_q[rd_tag_i];
  assign rd_ready_o = busy[rd_tag_i] && done[rd_tag_i];

  assign commit_has_rd_o = has_rd[head_idx];
  assign commit_rd_o     = rd_q[head_idx];
  assign commit_data_o   = data_q[head_idx];
  assign commit_tag_o    = head_idx;
  assign flush_pc_o      = flush_o ? pc_q[head_idx] : '0;
  assign count_o         = tail - head;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (head_exc) state_next = S_FLUSH;
      S_FLUSH: state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // Reset suppresses both pulses even though the entry state is still stale.
  always_comb begin
    flush_o        = 1'b0;
    commit_valid_o = 1'b0;
    if (!rst) begin
      case (state)
        S_RUN: begin
          flush_o        = head_exc;
          commit_valid_o = head_ok;
        end
        S_FLUSH: commit_valid_o = head_ok;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_o) begin
      head <= '0;
      tail <= '0;
      busy <= '0;
      done <= '0;
      exc  <= '0;
    end else begin
      if (wb_hit) begin
        done[wb_tag_i] <= 1'b1;
        exc[wb_tag_i]  <= wb_exc_i;
      end
      if (retire_fire) begin
        busy[head_idx] <= 1'b0;
        done[head_idx] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (alloc_fire) begin
        busy[tail_idx] <= 1'b1;
        done[tail_idx] <= 1'b0;
        exc[tail_idx]  <= 1'b0;
        tail           <= tail + 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by busy/done.
  always_ff @(posedge clk) begin
    if (wb_hit) data_q[wb_tag_i] <= wb_data_i;
    if (alloc_fire) begin
      has_rd[tail_idx] <= alloc_has_rd_i;
      rd_q[tail_idx]   <= alloc_rd_i;
      pc_q[tail_idx]   <= alloc_pc_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// tb_reorder_buffer: directed vectors with hand-computed expectations.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid_i, alloc_ready_o, alloc_has_rd_i;
  logic [4:0]  alloc_rd_i;
  logic [31:0] alloc_pc_i;
  logic [4:0]  alloc_tag_o;
  logic        wb_valid_i, wb_exc_i;
  logic [4:0]  wb_tag_i;
  logic [31:0] wb_data_i;
  logic [4:0]  rd_tag_i;
  logic [31:0] rd_data_o;
  logic        rd_ready_o;
  logic        commit_valid_o, commit_ready_i, commit_has_rd_o;
  logic [4:0]  commit_rd_o;
  logic [31:0] commit_data_o;
  logic [4:0]  commit_tag_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic [5:0]  count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_COUNT(32), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_has_rd_i(alloc_has_rd_i), .alloc_rd_i(alloc_rd_i),
    .alloc_pc_i(alloc_pc_i), .alloc_tag_o(alloc_tag_o),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
    .wb_exc_i(wb_exc_i), .rd_tag_i(rd_tag_i), .rd_data_o(rd_data_o),
    .rd_ready_o(rd_ready_o), .commit_valid_o(commit_valid_o),
    .commit_ready_i(commit_ready_i), .commit_has_rd_o(commit_has_rd_o),
    .commit_rd_o(commit_rd_o), .commit_data_o(commit_data_o),
    .commit_tag_o(commit_tag_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o),
    .count_o(count_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] tag, input logic [31:0] data, input logic e);
    wb_valid_i = 1'b1; wb_tag_i = tag; wb_data_i = data; wb_exc_i = e;
    tick();
    wb_valid_i = 1'b0; wb_exc_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alloc_valid_i = 1'b0; alloc_has_rd_i = 1'b0; alloc_rd_i = '0;
    alloc_pc_i = '0; wb_valid_i = 1'b0; wb_tag_i = '0; wb_data_i = '0;
    wb_exc_i = 1'b0; rd_tag_i = '0; commit_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_alloc_ready", alloc_ready_o, 1);
    check("rst_count", count_o, 0);
    check("rst_commit_valid", commit_valid_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_flush_pc", flush_pc_o, 0);

    // Three allocations: rd 1..3, pc 0x100/0x104/0x108
    for (int i = 0; i < 3; i++) begin
      alloc_valid_i = 1'b1; alloc_has_rd_i = 1'b1;
      alloc_rd_i = 5'(i + 1); alloc_pc_i = 32'h100 + 32'(4 * i);
      check($sformatf("alloc_tag_%0d", i), alloc_tag_o, i);
      tick();
    end
    alloc_valid_i = 1'b0;
    check("count3", count_o, 3);
    check("no_commit_pending", commit_valid_o, 0);

    // Out-of-order completion: tag 1 first must not retire
    wb(5'd1, 32'hAA, 1'b0);
    check("no_commit_tag1_only", commit_valid_o, 0);
    rd_tag_i = 5'd1;
    #1 check("rd_ready_tag1", rd_ready_o, 1);
    check("rd_data_tag1", rd_data_o, 32'hAA);
    rd_tag_i = 5'd0;
    #1 check("rd_ready_tag0", rd_ready_o, 0);

    commit_ready_i = 1'b1;
    wb(5'd0, 32'h55, 1'b0);
    check("c0_valid", commit_valid_o, 1);
    check("c0_rd", commit_rd_o, 1);
    check("c0_data", commit_data_o, 32'h55);
    check("c0_tag", commit_tag_o, 0);
    check("c0_has_rd", commit_has_rd_o, 1);
    tick();
    check("c1_valid", commit_valid_o, 1);
    check("c1_rd", commit_rd_o, 2);
    check("c1_data", commit_data_o, 32'hAA);
    check("c1_tag", commit_tag_o, 1);
    check("count_after_c0", count_o, 2);
    tick();
    check("count_after_c1", count_o, 1);
    check("c2_not_ready", commit_valid_o, 0);

    // Exception at the head (entry 2, pc 0x108)
    wb(5'd2, 32'hDEAD, 1'b1);
    check("flush_pulse", flush_o, 1);
    check("flush_pc", flush_pc_o, 32'h108);
    check("flush_no_commit", commit_valid_o, 0);
    check("flush_no_alloc", alloc_ready_o, 0);
    tick();
    check("flush_one_cycle", flush_o, 0);
    check("flush_count", count_o, 0);
    check("flush_tail", alloc_tag_o, 0);
    check("flush_alloc_ready", alloc_ready_o, 1);
    commit_ready_i = 1'b0;

    // Writeback to a non-busy tag on an empty buffer is ignored
    wb(5'd7, 32'h77, 1'b0);
    check("ghost_wb_count", count_o, 0);
    check("ghost_wb_commit", commit_valid_o, 0);

    // Fill all 32 entries
    for (int t = 0; t < 32; t++) begin
      alloc_valid_i = 1'b1; alloc_has_rd_i = t[0];
      alloc_rd_i = 5'(t); alloc_pc_i = 32'h200 + 32'(4 * t);
      check($sformatf("fill_tag_%0d", t), alloc_tag_o, t);
      tick();
    end
    alloc_valid_i = 1'b0;
    check("full_count", count_o, 32);
    check("full_not_ready", alloc_ready_o, 0);
    rd_tag_i = 5'd7;
    #1 check("tag7_not_ready", rd_ready_o, 0);

    // Head done but commit stalled for three cycles
    wb(5'd0, 32'h11, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_valid_%0d", k), commit_valid_o, 1);
      check($sformatf("stall_data_%0d", k), commit_data_o, 32'h11);
      check($sformatf("stall_tag_%0d", k), commit_tag_o, 0);
      check($sformatf("stall_has_rd_%0d", k), commit_has_rd_o, 0);
      check($sformatf("stall_count_%0d", k), count_o, 32);
      tick();
    end

    // Retire while full: no same-cycle allocation bypass
    commit_ready_i = 1'b1; alloc_valid_i = 1'b1; alloc_rd_i = 5'd5;
    alloc_pc_i = 32'h300; alloc_has_rd_i = 1'b1;
    #1 check("full_retire_valid", commit_valid_o, 1);
    check("full_no_bypass", alloc_ready_o, 0);
    tick();
    commit_ready_i = 1'b0;
    check("after_retire_count", count_o, 31);
    check("after_retire_ready", alloc_ready_o, 1);
    check("wrap_tag", alloc_tag_o, 0);
    check("next_head_tag", commit_tag_o, 1);
    check("next_head_idle", commit_valid_o, 0);
    tick();
    alloc_valid_i = 1'b0;
    check("rewrap_count", count_o, 32);
    check("rewrap_full", alloc_ready_o, 0);

    // Reset in the middle of operation with a retirable head
    wb(5'd1, 32'h99, 1'b0);
    check("pre_rst_valid", commit_valid_o, 1);
    check("pre_rst_data", commit_data_o, 32'h99);
    rst = 1'b1;
    #1 check("rst_cycle_no_commit", commit_valid_o, 0);
    check("rst_cycle_no_flush", flush_o, 0);
    tick();
    rst = 1'b0;
    check("post_rst_count", count_o, 0);
    check("post_rst_ready", alloc_ready_o, 1);
    check("post_rst_commit", commit_valid_o, 0);
    rd_tag_i = 5'd1;
    #1 check("post_rst_rd_ready", rd_ready_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
